// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word and write-mask types
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_word      LC3B_WORD_ZERO = 16'h0000;
  localparam lc3b_mem_wmask LC3B_MASK_FULL = 2'b11;

endpackage

// File: rtl/mem_bridge_timer.sv
// rtl/mem_bridge_timer.sv - BUSY-cycle watchdog for mem_bridge
// Built only when MEM_BRIDGE_TIMEOUT_EN is defined.
`ifdef MEM_BRIDGE_TIMEOUT_EN
module mem_bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Count saturates at the last value so a stalled enable cannot wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST_COUNT)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == LAST_COUNT);

endmodule
`endif

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - LC-3b CPU to physical-memory request bridge (IDLE/BUSY/DONE)
// Optional BUSY watchdog enabled by MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e        state_q, state_d;
  logic          op_read_q, op_read_d;
  lc3b_word      addr_q, addr_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_word      rdata_q, rdata_d;
  lc3b_mem_wmask be_q, be_d;
  logic          err_q, err_d;
  logic          expire;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  mem_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != ST_BUSY),
    .enable_i(state_q == ST_BUSY),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  // CPU inputs are only looked at in IDLE; everything downstream runs off the capture registers.
  always_comb begin
    state_d   = state_q;
    op_read_d = op_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    be_d      = be_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          op_read_d = mem_read;
          addr_d    = mem_address;
          if (mem_read) begin
            be_d = LC3B_MASK_FULL;
          end else begin
            wdata_d = mem_wdata;
            be_d    = mem_byte_enable;
          end
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A response landing in the expiry cycle still counts as a normal completion.
        if (pmem_resp) begin
          if (op_read_q) begin
            rdata_d = pmem_rdata;
          end
          state_d = ST_DONE;
        end else if (expire) begin
          rdata_d = LC3B_WORD_ZERO;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_read_q <= 1'b0;
      addr_q    <= LC3B_WORD_ZERO;
      wdata_q   <= LC3B_WORD_ZERO;
      rdata_q   <= LC3B_WORD_ZERO;
      be_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_read_q <= op_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      be_q      <= be_d;
      err_q     <= err_d;
    end
  end

  assign pmem_read        = (state_q == ST_BUSY) && op_read_q;
  assign pmem_write       = (state_q == ST_BUSY) && !op_read_q;
  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;
  assign mem_resp         = (state_q == ST_DONE);
  assign mem_rdata        = rdata_q;
  assign timeout_err      = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - randomized self-checking bench for mem_bridge against a transaction-level model
`timescale 1ns/1ps
module tb_mem_bridge;

  localparam int TO = 4;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] mem_address = '0, mem_wdata = '0;
  logic [1:0]  mem_byte_enable = '0;
  logic [15:0] mem_rdata;
  logic        mem_resp, pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  logic        timeout_err;

  mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: what the CPU should see after each completed transaction.
  logic [15:0] exp_rdata = 16'h0000;
  logic        exp_err = 1'b0;

  // Observations captured by the driver.
  int          obs_lat;
  logic        obs_rd, obs_wr, obs_stable, obs_done_quiet, obs_resp_one, obs_err_done;
  logic [15:0] obs_addr, obs_wdata, obs_rdata_done, obs_rdata_after;
  logic [1:0]  obs_be;

  task automatic model_txn(input bit rd, input logic [1:0] mask, input int delay,
                           input logic [15:0] pdata, output int lat, output logic [1:0] be);
    bit tmo;
    tmo = TO_EN && (delay > TO);
    lat = tmo ? TO + 1 : delay + 1;
    be  = rd ? 2'b11 : mask;
    if (tmo) begin
      exp_rdata = 16'h0000;
      exp_err   = 1'b1;
    end else if (rd) begin
      exp_rdata = pdata;
    end
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] mask, input int delay, input logic [15:0] pdata,
                         input bit perturb, input bit hold_done, input bit spurious);
    int budget;
    budget = (TO_EN ? TO : delay) + 10;
    obs_lat = -1; obs_rd = 1'bx; obs_wr = 1'bx; obs_addr = 'x; obs_wdata = 'x; obs_be = 'x;
    obs_stable = 1'b1; obs_done_quiet = 1'bx; obs_rdata_done = 'x; obs_err_done = 1'bx;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata; mem_byte_enable = mask;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp) begin
        obs_lat = c; obs_rdata_done = mem_rdata; obs_err_done = timeout_err;
        obs_done_quiet = !pmem_read && !pmem_write;
        break;
      end
      if (c == 1) begin
        obs_rd = pmem_read; obs_wr = pmem_write; obs_addr = pmem_address;
        obs_wdata = pmem_wdata; obs_be = pmem_byte_enable;
      end else if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable} !==
                   {obs_rd, obs_wr, obs_addr, obs_wdata, obs_be}) begin
        obs_stable = 1'b0;
      end
      if (perturb) begin
        mem_read = 1'($urandom); mem_write = 1'($urandom); mem_address = 16'($urandom);
        mem_wdata = 16'($urandom); mem_byte_enable = 2'($urandom);
      end
      pmem_rdata = (c == delay) ? pdata : 16'($urandom);
      pmem_resp  = (c == delay);
    end
    if (hold_done) begin
      mem_read = rd; mem_write = wr;
    end else begin
      mem_read = 1'b0; mem_write = 1'b0;
    end
    if (spurious) begin
      pmem_resp = 1'b1; pmem_rdata = 16'($urandom);
    end
    @(negedge clk);
    obs_resp_one = !mem_resp; obs_rdata_after = mem_rdata;
    pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
    n_checks++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write}); end
    n_checks++; if (pmem_address !== 16'h0000) begin n_fail++; $display("FAIL reset_pmem_address: got %h want 0000", pmem_address); end
    n_checks++; if (pmem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h want 0000", pmem_wdata); end
    n_checks++; if (pmem_byte_enable !== 2'b00) begin n_fail++; $display("FAIL reset_pmem_be: got %b want 00", pmem_byte_enable); end
    n_checks++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_rdata: got %h want 0000", mem_rdata); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    reset = 1'b0;
    exp_rdata = 16'h0000; exp_err = 1'b0;
  endtask

  task automatic test_read_basic();
    int el; logic [1:0] eb; logic [15:0] a;
    a = 16'($urandom);
    model_txn(1'b1, 2'b00, 1, 16'h1234, el, eb);
    run_txn(1'b1, 1'b0, a, 16'($urandom), 2'b01, 1, 16'h1234, 1'b0, 1'b0, 1'b0);
    n_checks++; if (obs_lat !== el) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", obs_lat, el); end
    n_checks++; if (obs_rdata_done !== 16'h1234) begin n_fail++; $display("FAIL read_rdata: got %h want 1234", obs_rdata_done); end
    n_checks++; if (obs_be !== eb) begin n_fail++; $display("FAIL read_be: got %b want %b", obs_be, eb); end
    n_checks++; if ({obs_rd, obs_wr} !== 2'b10) begin n_fail++; $display("FAIL read_strobes: got %b want 10", {obs_rd, obs_wr}); end
    n_checks++; if (obs_addr !== a) begin n_fail++; $display("FAIL read_addr: got %h want %h", obs_addr, a); end
    n_checks++; if (obs_resp_one !== 1'b1) begin n_fail++; $display("FAIL read_resp_width: got %b want 1", obs_resp_one); end
    n_checks++; if (obs_done_quiet !== 1'b1) begin n_fail++; $display("FAIL read_done_strobes: got %b want 1", obs_done_quiet); end
  endtask

  task automatic test_write_basic();
    int el; logic [1:0] eb;
    model_txn(1'b0, 2'b10, 5, 16'h0000, el, eb);
    run_txn(1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b10, 5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    n_checks++; if (obs_lat !== el) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", obs_lat, el); end
    n_checks++; if ({obs_rd, obs_wr} !== 2'b01) begin n_fail++; $display("FAIL write_strobes: got %b want 01", {obs_rd, obs_wr}); end
    n_checks++; if ({obs_addr, obs_wdata, obs_be} !== {16'h0040, 16'hBEEF, eb}) begin n_fail++; $display("FAIL write_fields: got %h/%h/%b want 0040/beef/%b", obs_addr, obs_wdata, obs_be, eb); end
    n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL write_stable: got %b want 1", obs_stable); end
    n_checks++; if (obs_rdata_after !== exp_rdata) begin n_fail++; $display("FAIL write_rdata_hold: got %h want %h", obs_rdata_after, exp_rdata); end
  endtask

  task automatic test_both_high();
    int el; logic [1:0] eb; logic [15:0] p;
    p = 16'($urandom);
    model_txn(1'b1, 2'b01, 2, p, el, eb);
    run_txn(1'b1, 1'b1, 16'h1000, 16'hFFFF, 2'b01, 2, p, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({obs_rd, obs_wr} !== 2'b10) begin n_fail++; $display("FAIL both_strobes: got %b want 10", {obs_rd, obs_wr}); end
    n_checks++; if (obs_be !== eb) begin n_fail++; $display("FAIL both_be: got %b want %b", obs_be, eb); end
    n_checks++; if (obs_rdata_done !== exp_rdata) begin n_fail++; $display("FAIL both_rdata: got %h want %h", obs_rdata_done, exp_rdata); end
  endtask

  task automatic test_random();
    bit rd, wr; logic [15:0] a, d, p; logic [1:0] m, eb; int dl, el;
    for (int i = 0; i < 20; i++) begin
      rd = 1'($urandom_range(0, 1)); wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a = 16'($urandom); d = 16'($urandom); p = 16'($urandom); m = 2'($urandom);
      dl = $urandom_range(1, 6);
      model_txn(rd, m, dl, p, el, eb);
      run_txn(rd, wr, a, d, m, dl, p, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      n_checks++; if (obs_lat !== el) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, obs_lat, el); end
      n_checks++; if ({obs_rd, obs_wr} !== {rd, !rd}) begin n_fail++; $display("FAIL rand%0d_strobes: got %b want %b", i, {obs_rd, obs_wr}, {rd, !rd}); end
      n_checks++; if ({obs_addr, obs_be} !== {a, eb}) begin n_fail++; $display("FAIL rand%0d_addr_be: got %h/%b want %h/%b", i, obs_addr, obs_be, a, eb); end
      if (!rd) begin
        n_checks++; if (obs_wdata !== d) begin n_fail++; $display("FAIL rand%0d_wdata: got %h want %h", i, obs_wdata, d); end
      end
      n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL rand%0d_stable: got %b want 1", i, obs_stable); end
      n_checks++; if ({obs_rdata_done, obs_rdata_after} !== {exp_rdata, exp_rdata}) begin n_fail++; $display("FAIL rand%0d_rdata: got %h/%h want %h", i, obs_rdata_done, obs_rdata_after, exp_rdata); end
      n_checks++; if ({obs_resp_one, obs_done_quiet} !== 2'b11) begin n_fail++; $display("FAIL rand%0d_done_shape: got %b want 11", i, {obs_resp_one, obs_done_quiet}); end
      n_checks++; if (obs_err_done !== exp_err) begin n_fail++; $display("FAIL rand%0d_timeout_err: got %b want %b", i, obs_err_done, exp_err); end
    end
  endtask

  task automatic test_back_to_back();
    int el; logic [1:0] eb; logic [15:0] p; bit quiet;
    p = 16'($urandom);
    model_txn(1'b1, 2'b00, 2, p, el, eb);
    run_txn(1'b1, 1'b0, 16'h2222, 16'h0, 2'b00, 2, p, 1'b0, 1'b1, 1'b1);
    n_checks++; if (obs_lat !== el) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", obs_lat, el); end
    n_checks++; if (obs_rdata_after !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", obs_rdata_after, exp_rdata); end
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (pmem_read || pmem_write || mem_resp) quiet = 1'b0;
    end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL b2b_single_txn: got %b want 1", quiet); end
    model_txn(1'b0, 2'b01, 1, 16'h0, el, eb);
    run_txn(1'b0, 1'b1, 16'h3333, 16'h4444, 2'b01, 1, 16'h0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({obs_lat, obs_wr, obs_wdata} !== {el, 1'b1, 16'h4444}) begin n_fail++; $display("FAIL b2b_next: got %0d/%b/%h want %0d/1/4444", obs_lat, obs_wr, obs_wdata, el); end
  endtask

  task automatic test_long_wait();
    int el; logic [1:0] eb; logic [15:0] p;
    p = 16'($urandom);
    model_txn(1'b1, 2'b00, 70, p, el, eb);
    run_txn(1'b1, 1'b0, 16'h7000, 16'h0, 2'b00, 70, p, 1'b0, 1'b0, 1'b0);
    n_checks++; if (obs_lat !== el) begin n_fail++; $display("FAIL long_latency: got %0d want %0d", obs_lat, el); end
    n_checks++; if ({obs_rdata_done, obs_err_done} !== {exp_rdata, exp_err}) begin n_fail++; $display("FAIL long_result: got %h/%b want %h/%b", obs_rdata_done, obs_err_done, exp_rdata, exp_err); end
  endtask

  task automatic test_reset_mid_busy();
    bit quiet;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'hABCD;
    repeat (3) @(negedge clk);
    n_checks++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b want 1", pmem_read); end
    reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    n_checks++; if ({pmem_read, pmem_write, mem_resp} !== 3'b000) begin n_fail++; $display("FAIL midrst_strobes: got %b want 000", {pmem_read, pmem_write, mem_resp}); end
    reset = 1'b0; pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    exp_rdata = 16'h0000; exp_err = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp || pmem_read || pmem_write) quiet = 1'b0;
    end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL midrst_no_resp: got %b want 1", quiet); end
    n_checks++; if ({mem_rdata, pmem_address, timeout_err} !== {exp_rdata, 16'h0000, exp_err}) begin n_fail++; $display("FAIL midrst_state: got %h/%h/%b want %h/0000/%b", mem_rdata, pmem_address, timeout_err, exp_rdata, exp_err); end
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int el; logic [1:0] eb; logic [15:0] p;
    p = 16'($urandom);
    model_txn(1'b1, 2'b00, TO, p, el, eb);
    run_txn(1'b1, 1'b0, 16'h0100, 16'h0, 2'b00, TO, p, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({obs_lat, obs_rdata_done, obs_err_done} !== {el, p, 1'b0}) begin n_fail++; $display("FAIL tmo_edge_wins: got %0d/%h/%b want %0d/%h/0", obs_lat, obs_rdata_done, obs_err_done, el, p); end
    model_txn(1'b1, 2'b00, 255, 16'h0, el, eb);
    run_txn(1'b1, 1'b0, 16'h0200, 16'h0, 2'b00, 255, 16'h0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (obs_lat !== el) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", obs_lat, el); end
    n_checks++; if ({obs_rdata_done, obs_err_done} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL tmo_result: got %h/%b want 0000/1", obs_rdata_done, obs_err_done); end
    repeat (3) @(negedge clk);
    n_checks++; if (timeout_err !== exp_err) begin n_fail++; $display("FAIL tmo_sticky: got %b want %b", timeout_err, exp_err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; exp_err = 1'b0; exp_rdata = 16'h0000;
    n_checks++; if (timeout_err !== exp_err) begin n_fail++; $display("FAIL tmo_clear: got %b want %b", timeout_err, exp_err); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_both_high();
    test_random();
    test_back_to_back();
    test_long_wait();
    test_reset_mid_busy();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, range 1..255: BUSY cycles without pmem_resp before abort (used only with MEM_BRIDGE_TIMEOUT_EN).
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports follow.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 mem_read  in  1  CPU read request; level, held until mem_resp.
REQ-006 mem_write  in  1  CPU write request; level, held until mem_resp.
REQ-007 mem_address  in  16  CPU byte address (lc3b_word).
REQ-008 mem_wdata  in  16  CPU write data.
REQ-009 mem_byte_enable  in  2  CPU write mask (lc3b_mem_wmask); bit0 = low byte.
REQ-010 mem_rdata  out  16  read data to CPU MDR path.
REQ-011 mem_resp  out  1  one-cycle completion pulse to CPU control.
REQ-012 pmem_read, pmem_write  out  1 each  physical-memory strobes.
REQ-013 pmem_address, pmem_wdata  out  16 each  registered request fields.
REQ-014 pmem_byte_enable  out  2  registered write mask.
REQ-015 pmem_rdata  in  16; pmem_resp  in  1  physical-memory data and completion.
REQ-016 timeout_err  out  1  sticky abort flag; always present.

Function
REQ-017 SHALL implement FSM IDLE, BUSY, DONE; all outputs registered or decoded from state/holding registers only, never from CPU inputs combinationally.
REQ-018 IDLE: mem_read or mem_write high -> capture address, wdata, byte_enable, op; next state BUSY.
REQ-019 mem_read and mem_write both high in IDLE -> read wins, write data ignored.
REQ-020 BUSY: pmem_read or pmem_write = 1 per captured op; other strobe 0; pmem_* fields from capture registers.
REQ-021 Reads drive pmem_byte_enable = 2'b11; writes drive captured mask.
REQ-022 BUSY with pmem_resp = 1 -> load rdata register from pmem_rdata (read only; write leaves it unchanged); next state DONE.
REQ-023 DONE: mem_resp = 1 exactly one cycle; strobes 0; mem_rdata = rdata register; next state IDLE unconditionally.
REQ-024 mem_rdata SHALL hold its value outside DONE until next read completion.
REQ-025 Latency: request accepted in cycle 0; pmem_resp first seen in cycle k >= 1; mem_resp in cycle k+1; minimum 3 cycles.
REQ-026 CPU requests that drop or change during BUSY/DONE SHALL be ignored; transaction still completes with mem_resp.
REQ-027 Request still high in DONE SHALL NOT launch a new transaction; acceptance only in IDLE.
REQ-028 pmem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE from any state, incl. mid-BUSY; the abandoned transaction produces no mem_resp.
REQ-030 Reset values: mem_resp 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, pmem_byte_enable 2'b00, mem_rdata 16'h0000, timeout_err 0, timer 0.

Configuration
REQ-031 Macro MEM_BRIDGE_TIMEOUT_EN defined: 8-bit timer counts BUSY cycles; TIMEOUT_CYCLES reached without pmem_resp -> DONE, mem_rdata = 16'h0000, timeout_err set sticky until reset; pmem_resp in the same cycle as expiry wins (normal completion).
REQ-032 Macro undefined: no timer; BUSY waits indefinitely; timeout_err tied 0.

Structure
REQ-033 lc3b_word and lc3b_mem_wmask SHALL come from shared package lc3b_types; FSM state enum stays local.
REQ-034 Timer SHALL be sub-module mem_bridge_timer (clear, enable, expire), instantiated only under MEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-035 Read, pmem_resp on first BUSY cycle, pmem_rdata 16'h1234 -> mem_resp in cycle 2 for one cycle, mem_rdata 16'h1234, pmem_byte_enable 2'b11.
REQ-036 Write addr 16'h0040, wdata 16'hBEEF, mask 2'b10, pmem_resp after 5 cycles -> pmem_write, addr, data, mask held stable throughout BUSY; mem_resp one cycle after pmem_resp; mem_rdata unchanged.
REQ-037 mem_read and mem_write both high -> only pmem_read asserted.
REQ-038 Reset in 3rd BUSY cycle -> strobes 0 next cycle; no mem_resp; later pmem_resp ignored.
REQ-039 MEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no pmem_resp -> mem_resp after 4 BUSY cycles, mem_rdata 16'h0000, timeout_err 1 until reset.
REQ-040 Back-to-back: request held high through DONE -> exactly one pmem transaction; next request accepted only from IDLE.
